// File: rtl/branch_controller.sv
// Branch resolution sequencer beside ID: waits for in-flight flag writers,
// evaluates the condition, then issues a registered redirect and an IF/ID flush.
module branch_controller #(
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16,
    parameter int PEND_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idValid,
    input  logic [1:0]        idOpType,
    input  logic [3:0]        idOpCode,
    input  logic [ADDR_W-1:0] idTarget,
    input  logic              flagWriteIssue,
    input  logic              flagWriteDone,
    input  logic [1:0]        flags,
    output logic              stall,
    output logic              pcSel,
    output logic [ADDR_W-1:0] pcTarget,
    output logic              flushIF,
    output logic              flushID,
    output logic [CNT_W-1:0]  branchCount,
    output logic [CNT_W-1:0]  takenCount,
    output logic              pendErr
);

    localparam int PW = $clog2(PEND_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} stateT;

    stateT             state, nextState;
    logic [PW-1:0]     pendCnt;
    logic [2:0]        flushLeft;
    logic [3:0]        heldOp;
    logic [ADDR_W-1:0] heldTarget;
    logic              isBranch, flagsReady;
    logic              stallInt, resolve, taken, latchNew;

    function automatic logic condMet(input logic [3:0] op, input logic [1:0] f);
        case (op)
            4'd0:    condMet = 1'b1;
            4'd1:    condMet = f[0];
            4'd2:    condMet = !f[0];
            4'd3:    condMet = f[0] | f[1];
            4'd4:    condMet = !f[0] & !f[1];
            default: condMet = 1'b0;
        endcase
    endfunction

    assign isBranch   = idValid && (idOpType == 2'b11) && (idOpCode <= 4'd4);
    assign flagsReady = (pendCnt == '0) && !flagWriteIssue;

    always_comb begin
        nextState = state;
        stallInt  = 1'b0;
        resolve   = 1'b0;
        taken     = 1'b0;
        latchNew  = 1'b0;
        case (state)
            IDLE: begin
                if (isBranch) begin
                    if ((idOpCode == 4'd0) || flagsReady) begin
                        resolve = 1'b1;
                        taken   = condMet(idOpCode, flags);
                        if (taken) begin
                            latchNew  = 1'b1;
                            nextState = FLUSH;
                        end
                    end else begin
                        stallInt  = 1'b1;
                        latchNew  = 1'b1;
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flagsReady) begin
                    resolve   = 1'b1;
                    taken     = condMet(heldOp, flags);
                    nextState = taken ? FLUSH : IDLE;
                end else begin
                    stallInt = 1'b1;
                end
            end
            FLUSH: begin
                if (flushLeft == 3'd0) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Stall is combinational; force it low while reset is held so outputs drop at once.
    assign stall    = stallInt & rst_n;
    assign flushIF  = (state == FLUSH);
    assign flushID  = (state == FLUSH);
    assign pcTarget = heldTarget;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pcSel       <= 1'b0;
            flushLeft   <= 3'd0;
            heldOp      <= 4'd0;
            heldTarget  <= '0;
            branchCount <= '0;
            takenCount  <= '0;
        end else begin
            state <= nextState;
            pcSel <= taken;
            if (latchNew) begin
                heldOp     <= idOpCode;
                heldTarget <= idTarget;
            end
            if (resolve) branchCount <= branchCount + 1'b1;
            if (taken) begin
                takenCount <= takenCount + 1'b1;
                flushLeft  <= 3'(FLUSH_DEPTH - 1);
            end else if ((state == FLUSH) && (flushLeft != 3'd0)) begin
                flushLeft <= flushLeft - 3'd1;
            end
        end
    end

    // Scoreboard of in-flight flag writers; saturates at both ends and flags misuse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendCnt <= '0;
            pendErr <= 1'b0;
        end else if (flagWriteIssue && !flagWriteDone) begin
            if (pendCnt == PW'(PEND_MAX)) pendErr <= 1'b1;
            else                          pendCnt <= pendCnt + 1'b1;
        end else if (flagWriteDone && !flagWriteIssue) begin
            if (pendCnt == '0) pendErr <= 1'b1;
            else               pendCnt <= pendCnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_controller.sv
// Directed bench for branch_controller: one default instance and one with a 3-cycle flush.
module tb_branch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idValid;
    logic [1:0]  idOpType;
    logic [3:0]  idOpCode;
    logic [31:0] idTarget;
    logic        flagWriteIssue, flagWriteDone;
    logic [1:0]  flags;

    logic        stall, pcSel, flushIF, flushID, pendErr;
    logic [31:0] pcTarget;
    logic [15:0] branchCount, takenCount;
    logic        stall3, pcSel3, flushIF3, flushID3, pendErr3;
    logic [31:0] pcTarget3;
    logic [15:0] branchCount3, takenCount3;

    int pass = 0;
    int total = 0;
    int expBr = 0;
    int expTk = 0;
    logic [3:0] tkTab [1:4];

    always #5 clk = ~clk;

    branch_controller dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idOpType(idOpType),
        .idOpCode(idOpCode), .idTarget(idTarget), .flagWriteIssue(flagWriteIssue),
        .flagWriteDone(flagWriteDone), .flags(flags), .stall(stall), .pcSel(pcSel),
        .pcTarget(pcTarget), .flushIF(flushIF), .flushID(flushID),
        .branchCount(branchCount), .takenCount(takenCount), .pendErr(pendErr)
    );

    branch_controller #(.FLUSH_DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .idOpType(idOpType),
        .idOpCode(idOpCode), .idTarget(idTarget), .flagWriteIssue(flagWriteIssue),
        .flagWriteDone(flagWriteDone), .flags(flags), .stall(stall3), .pcSel(pcSel3),
        .pcTarget(pcTarget3), .flushIF(flushIF3), .flushID(flushID3),
        .branchCount(branchCount3), .takenCount(takenCount3), .pendErr(pendErr3)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] tgt);
        idValid  = 1'b1;
        idOpType = 2'b11;
        idOpCode = op;
        idTarget = tgt;
    endtask

    task automatic test_reset;
        total++; if (stall !== 1'b0 || pcSel !== 1'b0 || flushIF !== 1'b0 || flushID !== 1'b0)
            $display("[TB] FAIL resetCtrl got stall=%b pcSel=%b flushIF=%b flushID=%b want 0", stall, pcSel, flushIF, flushID);
        else pass++;
        total++; if (branchCount !== 16'd0 || takenCount !== 16'd0 || pendErr !== 1'b0 || pcTarget !== 32'd0)
            $display("[TB] FAIL resetState got br=%0d tk=%0d err=%b tgt=%h want 0", branchCount, takenCount, pendErr, pcTarget);
        else pass++;
        step; rst_n = 1'b1;
        flagWriteIssue = 1'b1;
        step; flagWriteIssue = 1'b0;
        present(4'd1, 32'h200);
        #1;
        total++; if (stall !== 1'b1) $display("[TB] FAIL waitEnterStall got=%b want=1", stall); else pass++;
        step; #1;
        total++; if (stall !== 1'b1) $display("[TB] FAIL waitHoldStall got=%b want=1", stall); else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (stall !== 1'b0 || pcSel !== 1'b0 || flushIF !== 1'b0)
            $display("[TB] FAIL asyncReset got stall=%b pcSel=%b flushIF=%b want 0", stall, pcSel, flushIF);
        else pass++;
        idValid = 1'b0;
        step; rst_n = 1'b1;
        step;
        total++; if (pcSel !== 1'b0 || flushIF !== 1'b0 || branchCount !== 16'd0)
            $display("[TB] FAIL noRedirectAfterReset got pcSel=%b flushIF=%b br=%0d want 0", pcSel, flushIF, branchCount);
        else pass++;
        present(4'd1, 32'h0); #1;
        total++; if (stall !== 1'b0) $display("[TB] FAIL pendClearedByReset got stall=%b want=0", stall); else pass++;
        idValid = 1'b0;
    endtask

    task automatic test_uncond;
        flagWriteIssue = 1'b1;
        step; flagWriteIssue = 1'b0;
        present(4'd0, 32'h100); #1;
        total++; if (stall !== 1'b0) $display("[TB] FAIL uncondNoStall got=%b want=0", stall); else pass++;
        step; idValid = 1'b0;
        expBr++; expTk++;
        total++; if (pcSel !== 1'b1 || pcTarget !== 32'h100 || flushIF !== 1'b1 || flushID !== 1'b1)
            $display("[TB] FAIL uncondRedirect got pcSel=%b tgt=%h fIF=%b fID=%b want 1/100/1/1", pcSel, pcTarget, flushIF, flushID);
        else pass++;
        total++; if (branchCount !== 16'(expBr) || takenCount !== 16'(expTk))
            $display("[TB] FAIL uncondCounts got br=%0d tk=%0d want br=%0d tk=%0d", branchCount, takenCount, expBr, expTk);
        else pass++;
        step;
        total++; if (pcSel !== 1'b0 || flushIF !== 1'b0 || flushID !== 1'b0)
            $display("[TB] FAIL uncondPulseEnd got pcSel=%b fIF=%b fID=%b want 0", pcSel, flushIF, flushID);
        else pass++;
        flagWriteDone = 1'b1;
        step; flagWriteDone = 1'b0;
        repeat (3) step;
    endtask

    task automatic test_beq;
        flagWriteIssue = 1'b1;
        step; flagWriteIssue = 1'b0;
        flags = 2'b01;
        present(4'd1, 32'h300); #1;
        total++; if (stall !== 1'b1) $display("[TB] FAIL beqStallPending got=%b want=1", stall); else pass++;
        step; flagWriteDone = 1'b1; #1;
        total++; if (stall !== 1'b1) $display("[TB] FAIL beqStallDoneCycle got=%b want=1", stall); else pass++;
        step; flagWriteDone = 1'b0; #1;
        total++; if (stall !== 1'b0) $display("[TB] FAIL beqReleaseStall got=%b want=1'b0", stall); else pass++;
        step; idValid = 1'b0;
        expBr++; expTk++;
        total++; if (pcSel !== 1'b1 || pcTarget !== 32'h300 || takenCount !== 16'(expTk))
            $display("[TB] FAIL beqTaken got pcSel=%b tgt=%h tk=%0d want 1/300/%0d", pcSel, pcTarget, takenCount, expTk);
        else pass++;
        repeat (4) step;
        flagWriteIssue = 1'b1;
        step; flagWriteIssue = 1'b0;
        flags = 2'b00;
        present(4'd1, 32'h400);
        step; flagWriteDone = 1'b1;
        step; flagWriteDone = 1'b0;
        step; idValid = 1'b0;
        expBr++;
        total++; if (pcSel !== 1'b0 || flushIF !== 1'b0 || branchCount !== 16'(expBr) || takenCount !== 16'(expTk))
            $display("[TB] FAIL beqNotTaken got pcSel=%b fIF=%b br=%0d tk=%0d want 0/0/%0d/%0d", pcSel, flushIF, branchCount, takenCount, expBr, expTk);
        else pass++;
    endtask

    task automatic test_cond_table;
        tkTab[1] = 4'b1010;
        tkTab[2] = 4'b0101;
        tkTab[3] = 4'b1110;
        tkTab[4] = 4'b0001;
        for (int op = 1; op <= 4; op++) begin
            for (int f = 0; f < 4; f++) begin
                flags = 2'(f);
                present(4'(op), 32'h1000 + 32'(op * 16 + f)); #1;
                total++; if (stall !== 1'b0) $display("[TB] FAIL condNoStall op=%0d f=%0d got=%b want=0", op, f, stall); else pass++;
                step; idValid = 1'b0;
                expBr++;
                if (tkTab[op][f]) expTk++;
                total++; if (pcSel !== tkTab[op][f])
                    $display("[TB] FAIL condTaken op=%0d f=%0d got=%b want=%b", op, f, pcSel, tkTab[op][f]);
                else pass++;
                if (tkTab[op][f]) repeat (4) step;
            end
        end
        total++; if (branchCount !== 16'(expBr) || takenCount !== 16'(expTk))
            $display("[TB] FAIL condCounts got br=%0d tk=%0d want br=%0d tk=%0d", branchCount, takenCount, expBr, expTk);
        else pass++;
        flagWriteIssue = 1'b1;
        step; flagWriteIssue = 1'b0;
        present(4'd5, 32'h2000); #1;
        total++; if (stall !== 1'b0) $display("[TB] FAIL op5NoStall got=%b want=0", stall); else pass++;
        step; idValid = 1'b0;
        total++; if (pcSel !== 1'b0 || branchCount !== 16'(expBr))
            $display("[TB] FAIL op5Ignored got pcSel=%b br=%0d want 0/%0d", pcSel, branchCount, expBr);
        else pass++;
        flagWriteDone = 1'b1;
        step; flagWriteDone = 1'b0;
    endtask

    task automatic test_scoreboard;
        flagWriteIssue = 1'b1;
        step; flagWriteDone = 1'b1;
        step; flagWriteIssue = 1'b0; flagWriteDone = 1'b0;
        present(4'd1, 32'h0); #1;
        total++; if (stall !== 1'b1) $display("[TB] FAIL simulIssueDone got stall=%b want=1", stall); else pass++;
        idValid = 1'b0;
        flagWriteDone = 1'b1;
        step; flagWriteDone = 1'b0;
        present(4'd1, 32'h0); #1;
        total++; if (stall !== 1'b0 || pendErr !== 1'b0)
            $display("[TB] FAIL drainToZero got stall=%b err=%b want 0/0", stall, pendErr);
        else pass++;
        idValid = 1'b0;
        flagWriteDone = 1'b1;
        step; flagWriteDone = 1'b0;
        present(4'd1, 32'h0); #1;
        total++; if (pendErr !== 1'b1 || stall !== 1'b0)
            $display("[TB] FAIL underflow got err=%b stall=%b want 1/0", pendErr, stall);
        else pass++;
        idValid = 1'b0;
        rst_n = 1'b0; #2 rst_n = 1'b1;
        expBr = 0; expTk = 0;
        total++; if (pendErr !== 1'b0 || branchCount !== 16'd0)
            $display("[TB] FAIL errClearedByReset got err=%b br=%0d want 0/0", pendErr, branchCount);
        else pass++;
        flagWriteIssue = 1'b1;
        repeat (3) step;
        total++; if (pendErr !== 1'b0) $display("[TB] FAIL threeIssuesNoErr got=%b want=0", pendErr); else pass++;
        step; flagWriteIssue = 1'b0;
        total++; if (pendErr !== 1'b1) $display("[TB] FAIL overflow got=%b want=1", pendErr); else pass++;
        flagWriteDone = 1'b1;
        repeat (2) step;
        flagWriteDone = 1'b0;
        present(4'd1, 32'h0); #1;
        total++; if (stall !== 1'b1) $display("[TB] FAIL saturatedAt3 got stall=%b want=1", stall); else pass++;
        idValid = 1'b0;
        flagWriteDone = 1'b1;
        step; flagWriteDone = 1'b0;
        present(4'd1, 32'h0); #1;
        total++; if (stall !== 1'b0) $display("[TB] FAIL drainFrom3 got stall=%b want=0", stall); else pass++;
        idValid = 1'b0;
    endtask

    task automatic test_flush_depth;
        present(4'd0, 32'h500);
        step; idTarget = 32'h600;
        total++; if (pcSel3 !== 1'b1 || pcTarget3 !== 32'h500 || flushIF3 !== 1'b1 || stall3 !== 1'b0)
            $display("[TB] FAIL deep3T1 got pcSel=%b tgt=%h fIF=%b stall=%b want 1/500/1/0", pcSel3, pcTarget3, flushIF3, stall3);
        else pass++;
        step;
        total++; if (pcSel3 !== 1'b0 || flushIF3 !== 1'b1 || flushID3 !== 1'b1)
            $display("[TB] FAIL deep3T2 got pcSel=%b fIF=%b fID=%b want 0/1/1", pcSel3, flushIF3, flushID3);
        else pass++;
        step;
        total++; if (flushIF3 !== 1'b1 || flushID3 !== 1'b1)
            $display("[TB] FAIL deep3T3 got fIF=%b fID=%b want 1/1", flushIF3, flushID3);
        else pass++;
        step; idTarget = 32'h700;
        total++; if (flushIF3 !== 1'b0 || branchCount3 !== 16'd1 || takenCount3 !== 16'd1)
            $display("[TB] FAIL deep3End got fIF=%b br=%0d tk=%0d want 0/1/1", flushIF3, branchCount3, takenCount3);
        else pass++;
        step; idValid = 1'b0;
        total++; if (pcSel3 !== 1'b1 || pcTarget3 !== 32'h700 || branchCount3 !== 16'd2)
            $display("[TB] FAIL afterFlushBranch got pcSel=%b tgt=%h br=%0d want 1/700/2", pcSel3, pcTarget3, branchCount3);
        else pass++;
        repeat (4) step;
    endtask

    initial begin
        rst_n = 1'b0;
        idValid = 1'b0; idOpType = 2'b00; idOpCode = 4'd0; idTarget = 32'd0;
        flagWriteIssue = 1'b0; flagWriteDone = 1'b0; flags = 2'b00;
        #1;
        test_reset;
        test_uncond;
        test_beq;
        test_cond_table;
        test_scoreboard;
        test_flush_depth;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
